// File: rtl/nor32_pkg.sv
// Shared constants, types and helpers for the nor32 datapath.
package nor32_pkg;

  localparam int NOR32_WIDTH = 32;

  function automatic int popcnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int NOR32_CNT_W = popcnt_width(NOR32_WIDTH);

  typedef logic [NOR32_WIDTH-1:0] nor32_res_t;

endpackage

// File: rtl/nor32_popcnt.sv
// Combinational popcount as a balanced adder tree; zero latency, no flow control.
module nor32_popcnt
  import nor32_pkg::*;
#(
  parameter int WIDTH = NOR32_WIDTH
) (
  input  logic [WIDTH-1:0]               vec,
  output logic [popcnt_width(WIDTH)-1:0] cnt
);

  localparam int CW   = popcnt_width(WIDTH);
  localparam int LVLS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int N    = 1 << LVLS;

  // Level 0 holds one count per (zero-padded) input bit; each level halves the node count.
  for (genvar l = 0; l <= LVLS; l++) begin : lvl
    logic [CW*(N>>l)-1:0] sum;
    if (l == 0) begin : leaf
      for (genvar j = 0; j < N; j++) begin : b
        if (j < WIDTH) begin : live
          assign sum[j*CW +: CW] = CW'(vec[j]);
        end else begin : pad
          assign sum[j*CW +: CW] = '0;
        end
      end
    end else begin : node
      for (genvar j = 0; j < (N >> l); j++) begin : b
        assign sum[j*CW +: CW] = lvl[l-1].sum[(2*j)*CW +: CW] + lvl[l-1].sum[(2*j+1)*CW +: CW];
      end
    end
  end

  assign cnt = lvl[LVLS].sum[CW-1:0];

endmodule

// File: rtl/nor32.sv
// Registered bitwise NOR with zero/all-ones flags; 1-cycle latency, valid/ready, stalls hold output.
// Optional res_popcnt output when NOR32_POPCNT_EN is defined.
module nor32
  import nor32_pkg::*;
#(
  parameter int WIDTH = NOR32_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero,
  output logic             all_ones
`ifdef NOR32_POPCNT_EN
  ,
  output logic [popcnt_width(WIDTH)-1:0] res_popcnt
`endif
);

  logic [WIDTH-1:0] nxt;
  logic             take;

  assign nxt      = ~(A | B);
  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
      zero      <= 1'b1;
      all_ones  <= 1'b0;
    end else if (take) begin
      out_valid <= 1'b1;
      res       <= nxt;
      zero      <= ~|nxt;
      all_ones  <= &nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef NOR32_POPCNT_EN
  logic [popcnt_width(WIDTH)-1:0] nxt_cnt;

  nor32_popcnt #(.WIDTH(WIDTH)) u_popcnt (
    .vec (nxt),
    .cnt (nxt_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_popcnt <= '0;
    end else if (take) begin
      res_popcnt <= nxt_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_nor32.sv
// Scoreboard bench for nor32: directed vectors, stalls, back-to-back and async reset.
module tb_nor32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic [W-1:0] res;
  logic         out_valid;
  logic         zero;
  logic         all_ones;
`ifdef NOR32_POPCNT_EN
  logic [5:0]   res_popcnt;
`endif

  nor32 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res       (res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .zero      (zero),
    .all_ones  (all_ones)
`ifdef NOR32_POPCNT_EN
    ,
    .res_popcnt(res_popcnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         o;
    int           pc;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pop_cmp(input bit lat_chk);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_unexpected_out", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("res", res, e.r);
      chk("zero", zero, e.z);
      chk("all_ones", all_ones, e.o);
`ifdef NOR32_POPCNT_EN
      chk("popcnt", res_popcnt, e.pc);
`endif
      if (lat_chk) chk("latency", cyc - e.cyc, 1);
    end
  endtask

  // Called at a falling edge: drive, settle, score, then advance one cycle.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic v,
                      input logic rdy, input logic [W-1:0] ex, input bit lat_chk);
    exp_t e;
    A = a;
    B = b;
    in_valid = v;
    out_ready = rdy;
    #1;
    if (out_valid && out_ready) pop_cmp(lat_chk);
    if (in_valid && in_ready) begin
      e.r = ex;
      e.z = (ex == '0);
      e.o = &ex;
      e.pc = $countones(ex);
      e.cyc = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    logic v, r;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_zero", zero, 1);
    chk("rst_all_ones", all_ones, 0);
`ifdef NOR32_POPCNT_EN
    chk("rst_popcnt", res_popcnt, 0);
`endif
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    step(32'h0000FFFF, 32'h00FF00FF, 1, 1, 32'hFF000000, 1);
    step(32'h00000000, 32'h00000000, 1, 1, 32'hFFFFFFFF, 1);
    step(32'hFFFFFFFF, 32'h00000000, 1, 1, 32'h00000000, 1);
    step(32'h0, 32'h0, 0, 1, 32'h0, 1);
    chk("drain_empty", sbq.size(), 0);

    // Stall: held result must survive three cycles of ignored inputs.
    step(32'h12345678, 32'h0F0F0000, 1, 1, 32'hE0C0A987, 0);
    for (int i = 0; i < 3; i++) begin
      step($urandom, $urandom, 1, 0, 32'h0, 0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_res", res, 32'hE0C0A987);
      chk("stall_valid", out_valid, 1);
    end
    step(32'hAAAA0000, 32'h00005555, 1, 1, 32'h5555AAAA, 0);
    step(32'h0, 32'h0, 0, 1, 32'h0, 0);
    chk("stall_empty", sbq.size(), 0);

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      step(a, b, 1, 1, ~(a | b), 1);
      if (i > 0) chk("b2b_valid", out_valid, 1);
    end
    step(32'h0, 32'h0, 0, 1, 32'h0, 1);
    chk("b2b_empty", sbq.size(), 0);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = (i % 4 == 0) ? ~a : $urandom;
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      step(a, b, v, r, ~(a | b), 0);
    end
    step(32'h0, 32'h0, 0, 1, 32'h0, 0);
    step(32'h0, 32'h0, 0, 1, 32'h0, 0);
    chk("rand_empty", sbq.size(), 0);

    // Async reset between edges while a result is pending.
    step(32'h0F0F0F0F, 32'hF0F0F0F0, 1, 0, 32'h00000000, 0);
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_res", res, 0);
    chk("async_zero", zero, 1);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(32'h0, 32'h0, 0, 1, 32'h0, 0);
      chk("no_ghost_valid", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nor32.md
NOR32 -- requirements
Module: nor32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits; it SHALL be legal for values 1..64.
REQ-002 Port clk SHALL be input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be input, 1 bit, the reset: asynchronous, active-low.
REQ-004 Port A SHALL be input, WIDTH bits: first operand.
REQ-005 Port B SHALL be input, WIDTH bits: second operand.
REQ-006 Port in_valid SHALL be input, 1 bit: A/B valid this cycle.
REQ-007 Port in_ready SHALL be output, 1 bit: block accepts A/B this cycle.
REQ-008 Port res SHALL be output, WIDTH bits: registered bitwise NOR result.
REQ-009 Port out_valid SHALL be output, 1 bit: res and flags hold a valid result.
REQ-010 Port out_ready SHALL be input, 1 bit: consumer accepts the result this cycle.
REQ-011 Port zero SHALL be output, 1 bit: res is all zeros.
REQ-012 Port all_ones SHALL be output, 1 bit: res is all ones (A and B both zero).

Function
REQ-013 The result SHALL be res = ~(A | B), bit by bit, with no carries or cross-bit dependence.
REQ-014 A transfer in SHALL occur when in_valid and in_ready are both 1 at a rising clk edge.
REQ-015 in_ready SHALL be combinational: 1 when out_valid is 0 or out_ready is 1.
REQ-016 On a transfer in, res, zero, all_ones and (if enabled) res_popcnt SHALL load on that edge; out_valid SHALL be 1 from the next cycle on (latency 1 cycle).
REQ-017 A transfer out SHALL occur when out_valid and out_ready are both 1; if there is no transfer in on the same edge, out_valid SHALL clear.
REQ-018 A transfer in and a transfer out on the same edge SHALL replace the result with no bubble; out_valid SHALL stay 1 (full throughput, one result per cycle).
REQ-019 While out_valid is 1 and out_ready is 0, res and all flags SHALL hold stable and in_ready SHALL be 0.
REQ-020 zero and all_ones SHALL be computed from the loaded result, not from live inputs.
REQ-021 When out_valid is 0, the output data SHALL keep the last loaded values (not forced to zero).

Reset
REQ-022 While rst_n is 0, the block SHALL asynchronously force out_valid=0, res=0, zero=1, all_ones=0 and res_popcnt=0, independent of clk.
REQ-023 On reset release, in_ready SHALL be 1 immediately, and the first transfer SHALL be possible on the first rising edge after rst_n goes high.
REQ-024 A reset asserted mid-transfer SHALL discard the pending result; it SHALL never be presented.

Configuration
REQ-025 With macro NOR32_POPCNT_EN defined, the block SHALL add output res_popcnt, clog2(WIDTH+1) bits, holding the number of 1 bits in res, registered with res.
REQ-026 Without NOR32_POPCNT_EN, the block SHALL have no res_popcnt port and no popcount logic; all other behaviour SHALL be identical.

Structure
REQ-027 Shared package nor32_pkg SHALL hold the default WIDTH constant, the popcount-width function/constant and the result typedef.
REQ-028 The popcount SHALL be a sub-module nor32_popcnt, a purely combinational adder tree, instantiated only under NOR32_POPCNT_EN.

Verification
REQ-029 A bench SHALL check that with rst_n=0 and clk toggling, out_valid=0, res=0x00000000 and zero=1, and that in_ready=1 after release.
REQ-030 A bench SHALL drive A=0x0000FFFF, B=0x00FF00FF, in_valid=1, out_ready=1 and check that the next cycle gives res=0xFF000000, out_valid=1, zero=0, all_ones=0, res_popcnt=8.
REQ-031 A bench SHALL drive A=0, B=0 and check res=0xFFFFFFFF, all_ones=1, res_popcnt=32; then A=0xFFFFFFFF, B=0 and check res=0, zero=1, res_popcnt=0.
REQ-032 A bench SHALL hold out_ready=0 for 3 cycles after a result and check that res holds, in_ready=0 and new inputs are ignored; when out_ready=1 the held result SHALL transfer and the next input SHALL load.
REQ-033 A bench SHALL send back-to-back inputs for 8 cycles with in_valid=1 and out_ready=1 and check 8 consecutive results, in order, each one cycle after its input.
REQ-034 A bench SHALL assert rst_n=0 between clock edges while out_valid=1 and check that out_valid drops at once, before the next edge.
